tetris_i_sprite_fetch: RTL and testbench



---
 rtl/tetris_pkg.sv | 40 ++++
 rtl/tetris_I_rom.sv | 19 +
 rtl/tetris_i_sprite_fetch.sv | 149 ++++++++++++++
 tb/tb_tetris_i_sprite_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared constants and types for the Tetris renderer: coordinate widths, screen size,
// piece rotation encoding and the I-piece cell texture.
package tetris_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned CELL_LOG2 = 4;
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned ROM_AW    = 8;
  localparam int unsigned TEX_W     = 4;

  typedef enum logic {
    ROT_H = 1'b0,
    ROT_V = 1'b1
  } rot_t;

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_t;

  // 16x16 cell image: index 1 frame, transparent 2x2 window in the middle,
  // diagonal stripes of indices 8..11 elsewhere.
  function automatic logic [TEX_W-1:0] tex_lookup(input logic [ROM_AW-1:0] addr);
    logic [3:0] tx;
    logic [3:0] ty;
    logic [3:0] sum;
    tx  = addr[3:0];
    ty  = addr[7:4];
    sum = tx + ty;
    if (tx == 4'd0 || tx == 4'd15 || ty == 4'd0 || ty == 4'd15) begin
      return 4'h1;
    end
    if ((tx == 4'd7 || tx == 4'd8) && (ty == 4'd7 || ty == 4'd8)) begin
      return 4'h4;
    end
    return {2'b10, sum[1:0]};
  endfunction

endpackage

// File: rtl/tetris_I_rom.sv
// 256x4 synchronous-read texture ROM for the I-piece cell; data appears one cycle
// after the address. The image is generated from tex_lookup so it lives with the source.
module tetris_I_rom
  import tetris_pkg::*;
(
  input  logic              clk,
  input  logic [ROM_AW-1:0] i_addr,
  output logic [TEX_W-1:0]  o_data
);

  logic [TEX_W-1:0] r_data;

  always_ff @(posedge clk) begin
    r_data <= tex_lookup(i_addr);
  end

  assign o_data = r_data;

endmodule

// File: rtl/tetris_i_sprite_fetch.sv
// Per-pixel fetch stage for the falling I-piece: hit test, texture ROM read and
// registered palette index, with piece position committed only on vsync falling edge.
module tetris_i_sprite_fetch #(
  parameter int unsigned CELL_LOG2  = tetris_pkg::CELL_LOG2,
  parameter logic [3:0]  TRANSP_IDX = 4'h4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [tetris_pkg::COORD_W-1:0]  draw_x,
  input  logic [tetris_pkg::COORD_W-1:0]  draw_y,
  input  logic                            vs,
  input  logic                            pos_valid,
  output logic                            pos_ready,
  input  logic [tetris_pkg::COORD_W-1:0]  pos_x,
  input  logic [tetris_pkg::COORD_W-1:0]  pos_y,
  input  logic                            pos_rot,
  output logic [3:0]                      pix_index,
  output logic                            pix_hit
);

  import tetris_pkg::*;

  localparam logic [COORD_W:0] LIM_CELL  = (COORD_W + 1)'(1 << CELL_LOG2);
  localparam logic [COORD_W:0] LIM_PIECE = (COORD_W + 1)'(4 << CELL_LOG2);

  pend_state_t        r_pend_state;
  pend_state_t        w_pend_next;
  logic [COORD_W-1:0] r_pend_x;
  logic [COORD_W-1:0] r_pend_y;
  rot_t               r_pend_rot;

  logic               r_act_on;
  logic [COORD_W-1:0] r_act_x;
  logic [COORD_W-1:0] r_act_y;
  rot_t               r_act_rot;

  logic               r_vs_d;
  logic               w_edge;
  logic               w_commit_pend;
  logic               w_bypass;
  logic               w_load;

  logic [COORD_W:0]   w_dx;
  logic [COORD_W:0]   w_dy;
  logic [COORD_W:0]   w_dx_lim;
  logic [COORD_W:0]   w_dy_lim;
  logic               w_raw_hit;
  logic [ROM_AW-1:0]  w_rom_addr;
  logic [TEX_W-1:0]   w_tex;

  logic               r_hit1;
  logic [3:0]         r_pix_index;
  logic               r_pix_hit;

  assign pos_ready     = (r_pend_state == PEND_EMPTY);
  assign w_edge        = r_vs_d && !vs;
  assign w_commit_pend = w_edge && (r_pend_state == PEND_FULL);
  // An offer landing on the vsync edge with nothing pending goes straight to the
  // committed register; loading pending as well would replay it next frame.
  assign w_bypass      = w_edge && (r_pend_state == PEND_EMPTY) && pos_valid;
  assign w_load        = pos_valid && pos_ready && !w_bypass;

  always_comb begin
    w_pend_next = r_pend_state;
    case (r_pend_state)
      PEND_EMPTY: if (w_load) w_pend_next = PEND_FULL;
      PEND_FULL:  if (w_edge) w_pend_next = PEND_EMPTY;
      default:    w_pend_next = PEND_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_state <= PEND_EMPTY;
      r_pend_x     <= '0;
      r_pend_y     <= '0;
      r_pend_rot   <= ROT_H;
    end else begin
      r_pend_state <= w_pend_next;
      if (w_load) begin
        r_pend_x   <= pos_x;
        r_pend_y   <= pos_y;
        r_pend_rot <= rot_t'(pos_rot);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d    <= 1'b1;
      r_act_on  <= 1'b0;
      r_act_x   <= '0;
      r_act_y   <= '0;
      r_act_rot <= ROT_H;
    end else begin
      r_vs_d <= vs;
      if (w_commit_pend) begin
        r_act_on  <= 1'b1;
        r_act_x   <= r_pend_x;
        r_act_y   <= r_pend_y;
        r_act_rot <= r_pend_rot;
      end else if (w_bypass) begin
        r_act_on  <= 1'b1;
        r_act_x   <= pos_x;
        r_act_y   <= pos_y;
        r_act_rot <= rot_t'(pos_rot);
      end
    end
  end

  // 11-bit difference: the top bit flags a pixel left of / above the piece.
  assign w_dx = {1'b0, draw_x} - {1'b0, r_act_x};
  assign w_dy = {1'b0, draw_y} - {1'b0, r_act_y};

  always_comb begin
    w_dx_lim = LIM_PIECE;
    w_dy_lim = LIM_CELL;
    if (r_act_rot == ROT_V) begin
      w_dx_lim = LIM_CELL;
      w_dy_lim = LIM_PIECE;
    end
  end

  assign w_raw_hit  = r_act_on && !w_dx[COORD_W] && !w_dy[COORD_W] &&
                      (w_dx < w_dx_lim) && (w_dy < w_dy_lim);
  assign w_rom_addr = ROM_AW'({w_dy[CELL_LOG2-1:0], w_dx[CELL_LOG2-1:0]});

  tetris_I_rom u_rom (
    .clk    (clk),
    .i_addr (w_rom_addr),
    .o_data (w_tex)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit1      <= 1'b0;
      r_pix_index <= '0;
      r_pix_hit   <= 1'b0;
    end else begin
      r_hit1      <= w_raw_hit;
      r_pix_index <= r_hit1 ? w_tex : '0;
      r_pix_hit   <= r_hit1 && (w_tex != TRANSP_IDX);
    end
  end

  assign pix_index = r_pix_index;
  assign pix_hit   = r_pix_hit;

endmodule

// File: tb/tb_tetris_i_sprite_fetch.sv
// Scoreboard bench for tetris_i_sprite_fetch: every driven pixel queues its expected
// palette index and hit flag, checked two cycles later against the DUT.
module tb_tetris_i_sprite_fetch;

  logic       clk;
  logic       rst_n;
  logic [9:0] draw_x;
  logic [9:0] draw_y;
  logic       vs;
  logic       pos_valid;
  logic       pos_ready;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       pos_rot;
  logic [3:0] pix_index;
  logic       pix_hit;

  tetris_i_sprite_fetch #(
    .CELL_LOG2  (4),
    .TRANSP_IDX (4'h4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .draw_x    (draw_x),
    .draw_y    (draw_y),
    .vs        (vs),
    .pos_valid (pos_valid),
    .pos_ready (pos_ready),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .pos_rot   (pos_rot),
    .pix_index (pix_index),
    .pix_hit   (pix_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         x;
    int         y;
    logic [3:0] idx;
    logic       hit;
  } sb_t;

  sb_t sb[$];
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  // next-cycle stimulus, applied by step()
  logic [9:0] n_x = '0, n_y = '0, n_px = '0, n_py = '0;
  logic       n_vs = 1'b1, n_valid = 1'b0, n_rot = 1'b0;

  // reference model of pending/committed position
  logic       m_full, m_on, m_vs_d, m_prot, m_arot;
  int         m_px, m_py, m_ax, m_ay;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_tex(input int tx, input int ty);
    if (tx % 15 == 0 || ty % 15 == 0) return 4'd1;
    if (tx >= 7 && tx <= 8 && ty >= 7 && ty <= 8) return 4'd4;
    return 4'(8 + (tx + ty) % 4);
  endfunction

  task automatic model_reset();
    m_full = 1'b0; m_on = 1'b0; m_vs_d = 1'b1;
    m_px = 0; m_py = 0; m_prot = 1'b0;
    m_ax = 0; m_ay = 0; m_arot = 1'b0;
  endtask

  task automatic step();
    sb_t        e;
    int         dx, dy, wlim, hlim;
    logic       raw, edge_now;
    logic [3:0] tex;
    @(posedge clk);
    #2;
    draw_x = n_x; draw_y = n_y; vs = n_vs;
    pos_valid = n_valid; pos_x = n_px; pos_y = n_py; pos_rot = n_rot;
    check_eq("pos_ready", 32'(pos_ready), 32'(!m_full));
    dx   = int'(n_x) - m_ax;
    dy   = int'(n_y) - m_ay;
    wlim = m_arot ? 16 : 64;
    hlim = m_arot ? 64 : 16;
    raw  = m_on && dx >= 0 && dy >= 0 && dx < wlim && dy < hlim;
    tex  = raw ? ref_tex(dx % 16, dy % 16) : 4'd0;
    e.due = cyc + 2; e.x = int'(n_x); e.y = int'(n_y);
    e.idx = tex;
    e.hit = raw && (tex != 4'd4);
    sb.push_back(e);
    edge_now = m_vs_d && !n_vs;
    if (edge_now && m_full) begin
      m_on = 1'b1; m_ax = m_px; m_ay = m_py; m_arot = m_prot; m_full = 1'b0;
    end else if (edge_now && n_valid) begin
      m_on = 1'b1; m_ax = int'(n_px); m_ay = int'(n_py); m_arot = n_rot;
    end else if (n_valid && !m_full) begin
      m_full = 1'b1; m_px = int'(n_px); m_py = int'(n_py); m_prot = n_rot;
    end
    m_vs_d = n_vs;
  endtask

  task automatic scan_row(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) begin
      n_x = 10'(x); n_y = 10'(y);
      step();
    end
  endtask

  task automatic scan_col(input int x, input int y0, input int y1);
    for (int y = y0; y <= y1; y++) begin
      n_x = 10'(x); n_y = 10'(y);
      step();
    end
  endtask

  task automatic offer(input int x, input int y, input logic rot);
    n_valid = 1'b1; n_px = 10'(x); n_py = 10'(y); n_rot = rot;
    step();
    n_valid = 1'b0;
  endtask

  task automatic vsync_pulse();
    n_vs = 1'b0;
    repeat (3) step();
    n_vs = 1'b1;
    step();
  endtask

  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check_eq($sformatf("pix_index(%0d,%0d)", e.x, e.y), 32'(pix_index), 32'(e.idx));
        check_eq($sformatf("pix_hit(%0d,%0d)", e.x, e.y), 32'(pix_hit), 32'(e.hit));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; draw_x = '0; draw_y = '0; vs = 1'b1;
    pos_valid = 1'b0; pos_x = '0; pos_y = '0; pos_rot = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_pos_ready", 32'(pos_ready), 32'd1);
    check_eq("reset_pix_index", 32'(pix_index), 32'd0);
    check_eq("reset_pix_hit", 32'(pix_hit), 32'd0);
    #3 rst_n = 1'b1;

    // nothing committed yet: all misses
    scan_row(200, 98, 102);

    // accept mid-frame, invisible until the vsync edge
    offer(100, 200, 1'b0);
    scan_row(200, 99, 104);
    vsync_pulse();
    scan_row(200, 99, 164);
    scan_row(207, 100, 130);

    // right-edge clip, no wrap to the left side
    offer(620, 10, 1'b0);
    vsync_pulse();
    scan_row(10, 600, 639);
    scan_row(10, 0, 43);

    // second offer blocked while pending is full, accepted after the edge
    offer(0, 0, 1'b1);
    n_valid = 1'b1; n_px = 10'd300; n_py = 10'd300; n_rot = 1'b0;
    repeat (2) step();
    n_vs = 1'b0;
    repeat (2) step();
    n_valid = 1'b0;
    step();
    n_vs = 1'b1;
    step();
    scan_col(0, 0, 65);
    scan_col(15, 62, 65);
    scan_col(16, 0, 3);

    // pending (300,300) commits at the next edge
    vsync_pulse();
    scan_row(300, 298, 366);

    // offer on the edge itself with nothing pending: direct commit
    n_vs = 1'b0; n_valid = 1'b1; n_px = 10'd50; n_py = 10'd60; n_rot = 1'b1;
    step();
    n_valid = 1'b0;
    repeat (2) step();
    n_vs = 1'b1;
    step();
    scan_row(60, 45, 67);
    scan_row(60, 45, 58);

    // asynchronous reset mid-frame with hits in flight
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    check_eq("midrst_pix_hit", 32'(pix_hit), 32'd0);
    check_eq("midrst_pix_index", 32'(pix_index), 32'd0);
    check_eq("midrst_pos_ready", 32'(pos_ready), 32'd1);
    sb.delete();
    model_reset();
    n_vs = 1'b1; n_valid = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    scan_row(60, 48, 56);
    offer(100, 200, 1'b0);
    vsync_pulse();
    scan_row(200, 98, 103);

    repeat (3) step();
    repeat (3) @(posedge clk);
    #2;
    check_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
